// File: rtl/fifo_rd_unpack.sv
// rtl/fifo_rd_unpack.sv - read-side consumer that strips length headers from FIFO words
// and streams the payload with an end-of-packet marker.
module fifo_rd_unpack #(
    parameter int DSIZE = 8,
    parameter int CSIZE = 16
) (
    input  logic             rclk,
    input  logic             rrst_n,
    input  logic             rempty,
    input  logic [DSIZE-1:0] rdata,
    output logic             rinc,
    output logic [DSIZE-1:0] m_data,
    output logic             m_valid,
    output logic             m_last,
    input  logic             m_ready,
    output logic [CSIZE-1:0] pkt_cnt,
    output logic [CSIZE-1:0] err_cnt
);

    typedef enum logic {
        HDR = 1'b0,
        PAY = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [7:0]       rem, rem_nxt;
    logic [DSIZE-1:0] data_nxt;
    logic             valid_nxt;
    logic             last_nxt;
    logic [CSIZE-1:0] pkt_nxt;
    logic [CSIZE-1:0] err_nxt;
    logic [7:0]       hdr_len;

    // Only the low byte of a header carries the length; wider words ignore the rest.
    assign hdr_len = rdata[7:0];

    // Headers are popped regardless of the output register, so the next header
    // can be absorbed while the previous last word is still waiting.
    assign rinc = rrst_n & ~rempty & ((state == HDR) | ~m_valid | m_ready);

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            state   <= HDR;
            rem     <= 8'd0;
            m_data  <= '0;
            m_valid <= 1'b0;
            m_last  <= 1'b0;
            pkt_cnt <= '0;
            err_cnt <= '0;
        end else begin
            state   <= state_nxt;
            rem     <= rem_nxt;
            m_data  <= data_nxt;
            m_valid <= valid_nxt;
            m_last  <= last_nxt;
            pkt_cnt <= pkt_nxt;
            err_cnt <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        rem_nxt   = rem;
        data_nxt  = m_data;
        valid_nxt = m_valid;
        last_nxt  = m_last;
        pkt_nxt   = pkt_cnt;
        err_nxt   = err_cnt;

        case (state)
            HDR: begin
                if (m_ready) begin
                    valid_nxt = 1'b0;
                    last_nxt  = 1'b0;
                end
                if (rinc) begin
                    if (hdr_len == 8'd0) begin
                        err_nxt = err_cnt + CSIZE'(1);
                    end else begin
                        rem_nxt   = hdr_len - 8'd1;
                        state_nxt = PAY;
                    end
                end
            end
            PAY: begin
                if (rinc) begin
                    data_nxt  = rdata;
                    valid_nxt = 1'b1;
                    last_nxt  = (rem == 8'd0);
                    // Packet counted when its last word enters the output register.
                    if (rem == 8'd0) begin
                        state_nxt = HDR;
                        pkt_nxt   = pkt_cnt + CSIZE'(1);
                    end else begin
                        rem_nxt = rem - 8'd1;
                    end
                end else if (m_ready) begin
                    valid_nxt = 1'b0;
                    last_nxt  = 1'b0;
                end
            end
            default: state_nxt = HDR;
        endcase
    end

endmodule

// File: tb/tb_fifo_rd_unpack.sv
// tb/tb_fifo_rd_unpack.sv - directed bench for fifo_rd_unpack with a queue-based FIFO model.
module tb_fifo_rd_unpack;

    logic        rclk;
    logic        rrst_n;
    logic        rempty;
    logic [7:0]  rdata;
    logic        rinc;
    logic [7:0]  m_data;
    logic        m_valid;
    logic        m_last;
    logic        m_ready;
    logic [15:0] pkt_cnt;
    logic [15:0] err_cnt;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int viol   = 0;
    logic gate = 1'b0;

    logic [7:0] q[$];
    logic [7:0] recv_data[$];
    logic       recv_last[$];
    int         recv_cyc[$];

    fifo_rd_unpack #(.DSIZE(8), .CSIZE(16)) dut (
        .rclk    (rclk),
        .rrst_n  (rrst_n),
        .rempty  (rempty),
        .rdata   (rdata),
        .rinc    (rinc),
        .m_data  (m_data),
        .m_valid (m_valid),
        .m_last  (m_last),
        .m_ready (m_ready),
        .pkt_cnt (pkt_cnt),
        .err_cnt (err_cnt)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic upd();
        rempty = gate || (q.size() == 0);
        rdata  = (q.size() != 0) ? q[0] : 8'h00;
    endtask

    task automatic tick();
        logic       p, hs, l;
        logic [7:0] d;
        p  = rinc;
        hs = m_valid & m_ready;
        d  = m_data;
        l  = m_last;
        if (rinc && rempty) viol++;
        @(posedge rclk);
        cyc++;
        if (p) void'(q.pop_front());
        if (hs) begin
            recv_data.push_back(d);
            recv_last.push_back(l);
            recv_cyc.push_back(cyc);
        end
        #1;
        upd();
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic set_ready(input logic v);
        m_ready = v;
        #1;
    endtask

    task automatic clr_recv();
        recv_data.delete();
        recv_last.delete();
        recv_cyc.delete();
    endtask

    initial begin
        logic [4:0] rh;
        logic [7:0] held;
        int bad;
        int lastbad;
        int budget;

        rrst_n  = 1'b0;
        m_ready = 1'b0;
        q.push_back(8'h55);
        upd();
        run(3);
        check("rst_rinc", rinc, 0);
        check("rst_valid", m_valid, 0);
        check("rst_last", m_last, 0);
        check("rst_data", m_data, 0);
        check("rst_pkt", pkt_cnt, 0);
        check("rst_err", err_cnt, 0);
        check("rst_no_pop", q.size(), 1);
        q.delete();
        upd();
        rrst_n = 1'b1;
        #1;

        // single packet
        set_ready(1'b1);
        clr_recv();
        q.push_back(8'h03); q.push_back(8'hA1); q.push_back(8'hA2); q.push_back(8'hA3);
        upd();
        #1;
        rh = '0;
        for (int i = 0; i < 5; i++) begin
            rh = {rh[3:0], rinc};
            tick();
        end
        run(2);
        check("single_rinc", rh, 5'b11110);
        check("single_n", recv_data.size(), 3);
        check("single_d0", recv_data[0], 8'hA1);
        check("single_d1", recv_data[1], 8'hA2);
        check("single_d2", recv_data[2], 8'hA3);
        check("single_last", {recv_last[0], recv_last[1], recv_last[2]}, 3'b001);
        check("single_consec", recv_cyc[2] - recv_cyc[0], 2);
        check("single_pkt", pkt_cnt, 1);

        // back-pressure
        set_ready(1'b0);
        clr_recv();
        q.push_back(8'h03); q.push_back(8'hA1); q.push_back(8'hA2); q.push_back(8'hA3);
        upd();
        #1;
        budget = 0;
        while (!m_valid && budget < 10) begin
            tick();
            budget++;
        end
        check("bp_valid", m_valid, 1);
        check("bp_first", m_data, 8'hA1);
        held = m_data;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (rinc !== 1'b0 || m_data !== held || m_valid !== 1'b1) bad++;
            tick();
        end
        check("bp_hold", bad, 0);
        check("bp_fifo_held", q.size(), 2);
        set_ready(1'b1);
        run(6);
        check("bp_n", recv_data.size(), 3);
        check("bp_d0", recv_data[0], 8'hA1);
        check("bp_d1", recv_data[1], 8'hA2);
        check("bp_d2", recv_data[2], 8'hA3);
        check("bp_last", {recv_last[0], recv_last[1], recv_last[2]}, 3'b001);
        check("bp_pkt", pkt_cnt, 2);

        // zero-length header
        clr_recv();
        q.push_back(8'h00); q.push_back(8'h02); q.push_back(8'hB1); q.push_back(8'hB2);
        upd();
        #1;
        run(8);
        check("zl_err", err_cnt, 1);
        check("zl_n", recv_data.size(), 2);
        check("zl_d0", recv_data[0], 8'hB1);
        check("zl_d1", recv_data[1], 8'hB2);
        check("zl_last", {recv_last[0], recv_last[1]}, 2'b01);
        check("zl_pkt", pkt_cnt, 3);

        // header overlap
        set_ready(1'b0);
        clr_recv();
        q.push_back(8'h01); q.push_back(8'hC1); q.push_back(8'h01); q.push_back(8'hD1);
        upd();
        #1;
        run(6);
        check("ov_fifo", q.size(), 1);
        check("ov_data", m_data, 8'hC1);
        check("ov_valid", m_valid, 1);
        check("ov_last", m_last, 1);
        check("ov_rinc", rinc, 0);
        check("ov_pkt1", pkt_cnt, 4);
        set_ready(1'b1);
        tick();
        check("ov_next", m_data, 8'hD1);
        check("ov_next_last", m_last, 1);
        check("ov_pkt2", pkt_cnt, 5);
        run(3);
        check("ov_n", recv_data.size(), 2);
        check("ov_order", {recv_data[0], recv_data[1]}, 16'hC1D1);

        // max length with empty gaps
        clr_recv();
        viol = 0;
        q.push_back(8'hFF);
        for (int i = 0; i < 255; i++) q.push_back(8'(i));
        upd();
        #1;
        budget = 0;
        while (recv_data.size() < 255 && budget < 3000) begin
            gate = 1'($urandom_range(0, 1));
            upd();
            #1;
            tick();
            budget++;
        end
        gate = 1'b0;
        upd();
        run(3);
        check("max_n", recv_data.size(), 255);
        bad = 0;
        lastbad = 0;
        for (int i = 0; i < recv_data.size(); i++) begin
            if (recv_data[i] !== 8'(i)) bad++;
            if (recv_last[i] !== (i == 254)) lastbad++;
        end
        check("max_order", bad, 0);
        check("max_last", lastbad, 0);
        check("max_no_rinc_empty", viol, 0);
        check("max_pkt", pkt_cnt, 6);

        // reset mid-packet
        clr_recv();
        q.push_back(8'h05);
        for (int i = 1; i <= 5; i++) q.push_back(8'hE0 + 8'(i));
        upd();
        #1;
        budget = 0;
        while (recv_data.size() < 2 && budget < 20) begin
            tick();
            budget++;
        end
        check("mid_got2", recv_data.size(), 2);
        rrst_n = 1'b0;
        q.delete();
        q.push_back(8'h01); q.push_back(8'hF1);
        upd();
        #1;
        check("mid_valid", m_valid, 0);
        check("mid_last", m_last, 0);
        check("mid_data", m_data, 0);
        check("mid_pkt", pkt_cnt, 0);
        check("mid_err", err_cnt, 0);
        check("mid_rinc", rinc, 0);
        run(2);
        rrst_n = 1'b1;
        #1;
        clr_recv();
        run(6);
        check("post_n", recv_data.size(), 1);
        check("post_d", recv_data[0], 8'hF1);
        check("post_last", recv_last[0], 1);
        check("post_pkt", pkt_cnt, 1);
        check("post_err", err_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
